// File: rtl/fas_arbiter.sv
// Round-robin arbiter sharing one fasN adder/subtractor among R requesters.
// Each operation takes IDLE -> EXEC -> RESP; operands are latched so requesters cannot disturb a live op.
module fas_arbiter #(
   parameter int N = 32,
   parameter int R = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [R-1:0]   req,
   input  logic [R-1:0]   op,
   input  logic [R-1:0]   ci,
   input  logic [R*N-1:0] a_in,
   input  logic [R*N-1:0] b_in,
   output logic [R-1:0]   gnt,
   output logic [R-1:0]   done,
   output logic [N-1:0]   y_out,
   output logic           co_out,
   output logic           busy,
   output logic [N-1:0]   fas_a,
   output logic [N-1:0]   fas_b,
   output logic           fas_sel,
   output logic           fas_ci,
   input  logic [N-1:0]   fas_y,
   input  logic           fas_co
);

   // state | meaning
   // IDLE  | waiting for any req; picks winner from ptr onward
   // EXEC  | latched operands drive fasN; result captured at the edge
   // RESP  | done pulses to the winner; ptr advances past the winner
   localparam int IW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic          op_q, op_d;
   logic          ci_q, ci_d;
   logic [R-1:0]  gnt_q, gnt_d;
   logic [R-1:0]  done_q, done_d;
   logic [N-1:0]  y_q, y_d;
   logic          co_q, co_d;
   logic          busy_q, busy_d;

   logic          found;
   logic [IW-1:0] win;
   logic [IW:0]   cand;
   logic [N-1:0]  a_sel;
   logic [N-1:0]  b_sel;
   logic          op_sel;
   logic          ci_sel;

   // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two R never yields idx >= R.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      cand  = '0;
      for (int k = 0; k < R; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(R)) begin
            cand = cand - (IW+1)'(R);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = 1'b0;
      ci_sel = 1'b0;
      for (int i = 0; i < R; i++) begin
         if (win == IW'(i)) begin
            a_sel  = a_in[i*N +: N];
            b_sel  = b_in[i*N +: N];
            op_sel = op[i];
            ci_sel = ci[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      ci_d    = ci_q;
      gnt_d   = gnt_q;
      done_d  = done_q;
      y_d     = y_q;
      co_d    = co_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               idx_d   = win;
               a_d     = a_sel;
               b_d     = b_sel;
               op_d    = op_sel;
               ci_d    = ci_sel;
               gnt_d   = R'(1) << win;
               busy_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            y_d     = fas_y;
            co_d    = fas_co;
            done_d  = gnt_q;
            state_d = RESP;
         end
         RESP: begin
            ptr_d   = (idx_q == IW'(R-1)) ? '0 : idx_q + IW'(1);
            gnt_d   = '0;
            done_d  = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            done_d  = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         ci_q    <= 1'b0;
         gnt_q   <= '0;
         done_q  <= '0;
         y_q     <= '0;
         co_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         ci_q    <= ci_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         y_q     <= y_d;
         co_q    <= co_d;
         busy_q  <= busy_d;
      end
   end

   // fasN sees only latched operands, which hold outside EXEC as well.
   assign fas_a   = a_q;
   assign fas_b   = b_q;
   assign fas_sel = op_q;
   assign fas_ci  = ci_q;
   assign gnt     = gnt_q;
   assign done    = done_q;
   assign y_out   = y_q;
   assign co_out  = co_q;
   assign busy    = busy_q;

endmodule
